vpu_vec_ctrl: RTL and testbench



---
 rtl/vpu_vec_ctrl.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_vpu_vec_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vpu_vec_ctrl.sv
// Vector processing unit controller.
// Accepts one vector instruction at a time and walks its elements. For each
// element it reads A, reads B (or reuses a broadcast constant), computes every
// lane in parallel and writes C back to the scratch memory. Read waits are
// bounded by a timeout that aborts the instruction with err set.
module vpu_vec_ctrl #(
    parameter int DATA_W  = 32,
    parameter int LANES   = 4,
    parameter int ADDR_W  = 13,
    parameter int OP_W    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [31:0]               inst,
    input  logic                      inst_valid,
    output logic                      inst_ready,
    input  logic                      mem_rdy,
    output logic                      rd_en,
    output logic [ADDR_W-1:0]         rd_addr,
    input  logic                      rd_valid,
    input  logic [LANES*DATA_W-1:0]   rd_data,
    output logic                      wr_en,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [LANES*DATA_W-1:0]   wr_data,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    localparam int VW    = LANES * DATA_W;
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(0);
    localparam logic [OP_W-1:0] OP_SUB  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_RELU = OP_W'(2);
    localparam logic [OP_W-1:0] OP_MUL  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_MAX  = OP_W'(4);

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_CONST,
        S_WAIT_CONST,
        S_RD_A,
        S_WAIT_A,
        S_RD_B,
        S_WAIT_B,
        S_EXEC,
        S_WR_C,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [OP_W-1:0]     r_op;
    logic [4:0]          r_a_base;
    logic [4:0]          r_b_base;
    logic [4:0]          r_c_base;
    logic [3:0]          r_vlen_m1;
    logic                r_unary;
    logic                r_cmode;
    logic [3:0]          r_idx;
    logic [VW-1:0]       r_a;
    logic [VW-1:0]       r_b;
    logic [VW-1:0]       r_res;
    logic [TMO_W-1:0]    r_tmo;
    logic                r_err;
    logic                r_done;
    logic                r_rd_en;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic                r_wr_en;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic                r_busy;
    logic                r_inst_ready;

    logic [OP_W-1:0]     w_op;
    logic                w_illegal;
    logic                w_unary;
    logic                w_cmode;
    logic [ADDR_W-1:0]   w_a_addr;
    logic [ADDR_W-1:0]   w_a_next;
    logic [ADDR_W-1:0]   w_b_addr;
    logic [ADDR_W-1:0]   w_c_addr;
    logic                w_tmo_hit;
    logic                w_last;
    logic [VW-1:0]       w_res;
    logic                w_unused_hi;

    // One lane of the datapath; results wrap to DATA_W bits.
    function automatic logic signed [DATA_W-1:0] lane_op(
        input logic [OP_W-1:0]          op,
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        case (op)
            OP_ADD:  lane_op = a + b;
            OP_SUB:  lane_op = a - b;
            OP_RELU: lane_op = a[DATA_W-1] ? '0 : a;
            OP_MUL:  lane_op = a * b;
            OP_MAX:  lane_op = (a > b) ? a : b;
            default: lane_op = '0;
        endcase
    endfunction

    // Instruction field decode, only meaningful on the accept cycle.
    assign w_op        = inst[OP_W-1:0];
    assign w_illegal   = (w_op > OP_MAX);
    assign w_unary     = (w_op == OP_RELU);
    assign w_cmode     = !w_illegal && !w_unary && (inst[13:9] == 5'd0) && (inst[23:19] != 5'd0);
    assign w_unused_hi = ^inst[31:28];

    // Element addresses wrap modulo 2^ADDR_W.
    assign w_a_addr  = ADDR_W'(r_a_base) + ADDR_W'(r_idx);
    assign w_a_next  = ADDR_W'(r_a_base) + ADDR_W'(r_idx) + ADDR_W'(1);
    assign w_b_addr  = ADDR_W'(r_b_base) + ADDR_W'(r_idx);
    assign w_c_addr  = ADDR_W'(r_c_base) + ADDR_W'(r_idx);
    assign w_tmo_hit = (r_tmo == TMO_W'(TIMEOUT - 1));
    assign w_last    = (r_idx == r_vlen_m1);

    // Per-lane compute on the captured operands.
    always_comb begin
        w_res = '0;
        for (int l = 0; l < LANES; l++) begin
            w_res[l*DATA_W +: DATA_W] = lane_op(r_op, r_a[l*DATA_W +: DATA_W], r_b[l*DATA_W +: DATA_W]);
        end
    end

    // Controller FSM with registered memory-side and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_op         <= '0;
            r_a_base     <= '0;
            r_b_base     <= '0;
            r_c_base     <= '0;
            r_vlen_m1    <= '0;
            r_unary      <= 1'b0;
            r_cmode      <= 1'b0;
            r_idx        <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_res        <= '0;
            r_tmo        <= '0;
            r_err        <= 1'b0;
            r_done       <= 1'b0;
            r_rd_en      <= 1'b0;
            r_rd_addr    <= '0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_busy       <= 1'b0;
            r_inst_ready <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (inst_valid) begin
                        r_op         <= w_op;
                        r_a_base     <= inst[8:4];
                        r_b_base     <= inst[13:9];
                        r_c_base     <= inst[18:14];
                        r_vlen_m1    <= inst[27:24];
                        r_unary      <= w_unary;
                        r_cmode      <= w_cmode;
                        r_idx        <= '0;
                        r_err        <= 1'b0;
                        r_inst_ready <= 1'b0;
                        r_busy       <= 1'b1;
                        if (w_illegal) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end else if (w_cmode) begin
                            r_state   <= S_RD_CONST;
                            r_rd_en   <= 1'b1;
                            r_rd_addr <= ADDR_W'(inst[23:19]);
                        end else begin
                            r_state   <= S_RD_A;
                            r_rd_en   <= 1'b1;
                            r_rd_addr <= ADDR_W'(inst[8:4]);
                        end
                    end
                end
                S_RD_CONST: begin
                    if (mem_rdy) begin
                        r_rd_en <= 1'b0;
                        r_tmo   <= '0;
                        r_state <= S_WAIT_CONST;
                    end
                end
                S_WAIT_CONST: begin
                    if (rd_valid) begin
                        r_b       <= rd_data;
                        r_rd_en   <= 1'b1;
                        r_rd_addr <= w_a_addr;
                        r_state   <= S_RD_A;
                    end else if (w_tmo_hit) begin
                        r_err   <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                S_RD_A: begin
                    if (mem_rdy) begin
                        r_rd_en <= 1'b0;
                        r_tmo   <= '0;
                        r_state <= S_WAIT_A;
                    end
                end
                S_WAIT_A: begin
                    if (rd_valid) begin
                        r_a <= rd_data;
                        if (r_unary || r_cmode) begin
                            r_state <= S_EXEC;
                        end else begin
                            r_rd_en   <= 1'b1;
                            r_rd_addr <= w_b_addr;
                            r_state   <= S_RD_B;
                        end
                    end else if (w_tmo_hit) begin
                        r_err   <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                S_RD_B: begin
                    if (mem_rdy) begin
                        r_rd_en <= 1'b0;
                        r_tmo   <= '0;
                        r_state <= S_WAIT_B;
                    end
                end
                S_WAIT_B: begin
                    if (rd_valid) begin
                        r_b     <= rd_data;
                        r_state <= S_EXEC;
                    end else if (w_tmo_hit) begin
                        r_err   <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                S_EXEC: begin
                    r_res     <= w_res;
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= w_c_addr;
                    r_state   <= S_WR_C;
                end
                S_WR_C: begin
                    if (mem_rdy) begin
                        r_wr_en <= 1'b0;
                        if (w_last) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_idx     <= r_idx + 4'd1;
                            r_rd_en   <= 1'b1;
                            r_rd_addr <= w_a_next;
                            r_state   <= S_RD_A;
                        end
                    end
                end
                S_DONE: begin
                    r_busy       <= 1'b0;
                    r_inst_ready <= 1'b1;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign inst_ready = r_inst_ready;
    assign rd_en      = r_rd_en;
    assign rd_addr    = r_rd_addr;
    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_res;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;

endmodule

// File: tb/tb_vpu_vec_ctrl.sv
// Directed bench for vpu_vec_ctrl with a 1-cycle-latency scratch memory model.
module tb_vpu_vec_ctrl;

    localparam int DW  = 32;
    localparam int LN  = 4;
    localparam int AW  = 13;
    localparam int TMO = 64;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [31:0]       inst = '0;
    logic              inst_valid = 1'b0;
    logic              inst_ready;
    logic              mem_rdy = 1'b1;
    logic              rd_en;
    logic [AW-1:0]     rd_addr;
    logic              rd_valid = 1'b0;
    logic [LN*DW-1:0]  rd_data = '0;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [LN*DW-1:0]  wr_data;
    logic              busy;
    logic              done;
    logic              err;

    logic [LN*DW-1:0]  mem [0:63];
    logic              withhold = 1'b0;
    int                n_rd = 0;
    int                n_wr = 0;
    int                n_both = 0;
    logic [AW-1:0]     rlog [0:255];
    logic [AW-1:0]     wlog_a [0:255];
    logic [LN*DW-1:0]  wlog_d [0:255];

    int total = 0;
    int bad = 0;

    vpu_vec_ctrl #(
        .DATA_W(DW), .LANES(LN), .ADDR_W(AW), .OP_W(4), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .inst(inst), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .mem_rdy(mem_rdy), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_valid(rd_valid), .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Scratch memory model: accepted reads answer one cycle later, writes are logged.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            if (rd_en && mem_rdy) begin
                rlog[n_rd[7:0]] <= rd_addr;
                n_rd <= n_rd + 1;
                if (!withhold) begin
                    rd_valid <= 1'b1;
                    rd_data  <= mem[rd_addr[5:0]];
                end
            end
            if (wr_en && mem_rdy) begin
                wlog_a[n_wr[7:0]] <= wr_addr;
                wlog_d[n_wr[7:0]] <= wr_data;
                n_wr <= n_wr + 1;
            end
            if (rd_en && wr_en) n_both <= n_both + 1;
        end
    end

    function automatic logic [LN*DW-1:0] pk(input logic [31:0] l0, l1, l2, l3);
        pk = {l3, l2, l1, l0};
    endfunction

    function automatic logic [31:0] mk(input logic [3:0] op, input logic [4:0] a, b, c, k,
                                       input logic [3:0] vm1);
        mk = {4'hA, vm1, k, c, b, a, op};
    endfunction

    // Offer the instruction at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic [31:0] w);
        inst = w;
        inst_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        inst_valid = 1'b0;
        inst = 32'hFFFF_FFFF;
    endtask

    // Cycle count where 1 is the cycle right after the accept edge.
    task automatic wait_done(output int lat);
        lat = 1;
        while (done !== 1'b1 && lat < 400) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", done); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", err); end
        total++; if (rd_en !== 1'b0 || wr_en !== 1'b0) begin bad++; $display("FAIL rst_en: got rd=%b wr=%b want 0 0", rd_en, wr_en); end
        total++; if (wr_data !== '0) begin bad++; $display("FAIL rst_wdata: got %h want 0", wr_data); end
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (inst_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", inst_ready); end
    endtask

    task automatic test_add;
        int lat, r0, w0;
        mem[3] = pk(1, 2, 3, 4);
        mem[5] = pk(10, 20, 30, 40);
        r0 = n_rd; w0 = n_wr;
        issue(mk(4'd0, 5'd3, 5'd5, 5'd7, 5'd0, 4'd0));
        wait_done(lat);
        total++; if (lat != 7) begin bad++; $display("FAIL add_lat: got %0d want 7", lat); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL add_err: got %b want 0", err); end
        total++; if (n_rd - r0 != 2) begin bad++; $display("FAIL add_nrd: got %0d want 2", n_rd - r0); end
        total++; if (n_wr - w0 != 1) begin bad++; $display("FAIL add_nwr: got %0d want 1", n_wr - w0); end
        total++; if (wlog_a[w0[7:0]] !== AW'(7)) begin bad++; $display("FAIL add_waddr: got %0d want 7", wlog_a[w0[7:0]]); end
        total++; if (wlog_d[w0[7:0]] !== pk(11, 22, 33, 44)) begin bad++; $display("FAIL add_wdata: got %h want %h", wlog_d[w0[7:0]], pk(11, 22, 33, 44)); end
        @(negedge clk);
        total++; if (done !== 1'b0 || inst_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL add_idle: got done=%b rdy=%b busy=%b want 0 1 0", done, inst_ready, busy); end
    endtask

    task automatic test_max;
        int lat, w0;
        mem[30] = pk(-3, 5, 32'h7FFF_FFFF, -1);
        mem[31] = pk(-4, 6, 32'h8000_0000, 0);
        w0 = n_wr;
        issue(mk(4'd4, 5'd30, 5'd31, 5'd9, 5'd0, 4'd0));
        wait_done(lat);
        total++; if (lat != 7) begin bad++; $display("FAIL max_lat: got %0d want 7", lat); end
        total++; if (wlog_d[w0[7:0]] !== pk(-3, 6, 32'h7FFF_FFFF, 0)) begin bad++; $display("FAIL max_wdata: got %h want %h", wlog_d[w0[7:0]], pk(-3, 6, 32'h7FFF_FFFF, 0)); end
        @(negedge clk);
    endtask

    task automatic test_relu;
        int lat, r0, w0;
        logic [LN*DW-1:0] exp_d [0:2];
        mem[4] = pk(-5, 7, -1, 100);
        mem[5] = pk(9, -9, 32'h7FFF_FFFF, 0);
        mem[6] = pk(32'h8000_0000, 1, 2, 3);
        exp_d[0] = pk(0, 7, 0, 100);
        exp_d[1] = pk(9, 0, 32'h7FFF_FFFF, 0);
        exp_d[2] = pk(0, 1, 2, 3);
        r0 = n_rd; w0 = n_wr;
        issue(mk(4'd2, 5'd4, 5'd10, 5'd12, 5'd0, 4'd2));
        wait_done(lat);
        total++; if (lat != 13) begin bad++; $display("FAIL relu_lat: got %0d want 13", lat); end
        total++; if (n_rd - r0 != 3) begin bad++; $display("FAIL relu_nrd: got %0d want 3", n_rd - r0); end
        total++; if (n_wr - w0 != 3) begin bad++; $display("FAIL relu_nwr: got %0d want 3", n_wr - w0); end
        for (int i = 0; i < 3; i++) begin
            total++; if (rlog[8'(r0 + i)] !== AW'(4 + i)) begin bad++; $display("FAIL relu_raddr%0d: got %0d want %0d", i, rlog[8'(r0 + i)], 4 + i); end
            total++; if (wlog_a[8'(w0 + i)] !== AW'(12 + i)) begin bad++; $display("FAIL relu_waddr%0d: got %0d want %0d", i, wlog_a[8'(w0 + i)], 12 + i); end
            total++; if (wlog_d[8'(w0 + i)] !== exp_d[i]) begin bad++; $display("FAIL relu_wdata%0d: got %h want %h", i, wlog_d[8'(w0 + i)], exp_d[i]); end
        end
        @(negedge clk);
    endtask

    task automatic test_mul_const;
        int lat, r0, w0;
        logic [LN*DW-1:0] exp_d [0:3];
        logic [AW-1:0]    exp_r [0:4];
        mem[0]  = pk(99, 99, 99, 99);
        mem[2]  = pk(3, 3, 3, 3);
        mem[8]  = pk(1, 2, 3, 4);
        mem[9]  = pk(-7, 0, 32'h4000_0001, 100);
        mem[10] = pk(5, 5, 5, 5);
        mem[11] = pk(-1, 10, 11, 12);
        exp_d[0] = pk(3, 6, 9, 12);
        exp_d[1] = pk(32'hFFFF_FFEB, 0, 32'hC000_0003, 300);
        exp_d[2] = pk(15, 15, 15, 15);
        exp_d[3] = pk(32'hFFFF_FFFD, 30, 33, 36);
        exp_r[0] = AW'(2); exp_r[1] = AW'(8); exp_r[2] = AW'(9); exp_r[3] = AW'(10); exp_r[4] = AW'(11);
        r0 = n_rd; w0 = n_wr;
        issue(mk(4'd3, 5'd8, 5'd0, 5'd24, 5'd2, 4'd3));
        wait_done(lat);
        total++; if (lat != 19) begin bad++; $display("FAIL mulc_lat: got %0d want 19", lat); end
        total++; if (n_rd - r0 != 5) begin bad++; $display("FAIL mulc_nrd: got %0d want 5", n_rd - r0); end
        total++; if (n_wr - w0 != 4) begin bad++; $display("FAIL mulc_nwr: got %0d want 4", n_wr - w0); end
        for (int i = 0; i < 5; i++) begin
            total++; if (rlog[8'(r0 + i)] !== exp_r[i]) begin bad++; $display("FAIL mulc_raddr%0d: got %0d want %0d", i, rlog[8'(r0 + i)], exp_r[i]); end
        end
        for (int i = 0; i < 4; i++) begin
            total++; if (wlog_a[8'(w0 + i)] !== AW'(24 + i)) begin bad++; $display("FAIL mulc_waddr%0d: got %0d want %0d", i, wlog_a[8'(w0 + i)], 24 + i); end
            total++; if (wlog_d[8'(w0 + i)] !== exp_d[i]) begin bad++; $display("FAIL mulc_wdata%0d: got %h want %h", i, wlog_d[8'(w0 + i)], exp_d[i]); end
        end
        @(negedge clk);
    endtask

    task automatic test_stall;
        int lat, phase, scnt, w0;
        logic [LN*DW-1:0] exp_d;
        mem[12] = pk(100, 5, 0, -3);
        mem[13] = pk(1, 10, 1, -3);
        exp_d = pk(99, -5, -1, 0);
        w0 = n_wr;
        phase = 0; scnt = 0;
        issue(mk(4'd1, 5'd12, 5'd13, 5'd21, 5'd0, 4'd0));
        lat = 1;
        while (done !== 1'b1 && lat < 400) begin
            @(negedge clk);
            lat++;
            if (phase == 0 && rd_en === 1'b1 && rd_addr === AW'(13)) begin
                mem_rdy = 1'b0; phase = 1;
            end else if (phase == 1) begin
                scnt++;
                total++; if (rd_en !== 1'b1 || rd_addr !== AW'(13)) begin bad++; $display("FAIL stall_rd%0d: got en=%b addr=%0d want 1 13", scnt, rd_en, rd_addr); end
                if (scnt == 10) begin mem_rdy = 1'b1; phase = 2; scnt = 0; end
            end else if (phase == 2 && wr_en === 1'b1) begin
                mem_rdy = 1'b0; phase = 3;
            end else if (phase == 3) begin
                scnt++;
                total++; if (wr_en !== 1'b1 || wr_addr !== AW'(21) || wr_data !== exp_d) begin bad++; $display("FAIL stall_wr%0d: got en=%b addr=%0d data=%h want 1 21 %h", scnt, wr_en, wr_addr, wr_data, exp_d); end
                if (scnt == 10) begin mem_rdy = 1'b1; phase = 4; end
            end
        end
        mem_rdy = 1'b1;
        total++; if (lat != 27) begin bad++; $display("FAIL stall_lat: got %0d want 27", lat); end
        total++; if (n_wr - w0 != 1 || wlog_d[w0[7:0]] !== exp_d) begin bad++; $display("FAIL stall_wdata: got n=%0d data=%h want 1 %h", n_wr - w0, wlog_d[w0[7:0]], exp_d); end
        @(negedge clk);
    endtask

    task automatic test_timeout;
        int lat, r0, w0;
        mem[3] = pk(1, 2, 3, 4);
        mem[5] = pk(10, 20, 30, 40);
        r0 = n_rd; w0 = n_wr;
        withhold = 1'b1;
        issue(mk(4'd0, 5'd3, 5'd5, 5'd14, 5'd0, 4'd0));
        wait_done(lat);
        withhold = 1'b0;
        // WAIT_A is entered after the second edge; done follows TMO cycles later.
        total++; if (lat != TMO + 2) begin bad++; $display("FAIL tmo_lat: got %0d want %0d", lat, TMO + 2); end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL tmo_err: got %b want 1", err); end
        total++; if (n_wr - w0 != 0) begin bad++; $display("FAIL tmo_nwr: got %0d want 0", n_wr - w0); end
        total++; if (n_rd - r0 != 1) begin bad++; $display("FAIL tmo_nrd: got %0d want 1", n_rd - r0); end
        @(negedge clk);
        total++; if (err !== 1'b1 || inst_ready !== 1'b1) begin bad++; $display("FAIL tmo_hold: got err=%b rdy=%b want 1 1", err, inst_ready); end
    endtask

    task automatic test_illegal;
        int lat, r0, w0;
        r0 = n_rd; w0 = n_wr;
        issue(mk(4'd9, 5'd3, 5'd5, 5'd7, 5'd0, 4'd0));
        wait_done(lat);
        total++; if (lat > 2) begin bad++; $display("FAIL ill_lat: got %0d want <=2", lat); end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL ill_err: got %b want 1", err); end
        total++; if (n_rd != r0 || n_wr != w0) begin bad++; $display("FAIL ill_mem: got rd=%0d wr=%0d want 0 0", n_rd - r0, n_wr - w0); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int cyc, w0;
        mem[16] = pk(1, 1, 1, 1);
        mem[17] = pk(2, 2, 2, 2);
        mem[18] = pk(3, 3, 3, 3);
        mem[20] = pk(2, 2, 2, 2);
        mem[21] = pk(2, 2, 2, 2);
        mem[22] = pk(2, 2, 2, 2);
        w0 = n_wr;
        issue(mk(4'd0, 5'd16, 5'd20, 5'd28, 5'd0, 4'd2));
        cyc = 1;
        while (!(wr_en === 1'b1 && wr_addr === AW'(29)) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        total++; if (wr_en !== 1'b1) begin bad++; $display("FAIL rmid_reach: got wr_en=%b want 1", wr_en); end
        rst_n = 1'b0;
        #1;
        total++; if (wr_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL rmid_drop: got wr=%b busy=%b done=%b want 0 0 0", wr_en, busy, done); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (inst_ready !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL rmid_ready: got rdy=%b busy=%b err=%b want 1 0 0", inst_ready, busy, err); end
        total++; if (n_wr - w0 != 1) begin bad++; $display("FAIL rmid_nwr: got %0d want 1", n_wr - w0); end
        total++; if (wlog_a[w0[7:0]] !== AW'(28) || wlog_d[w0[7:0]] !== pk(3, 3, 3, 3)) begin bad++; $display("FAIL rmid_w0: got %0d %h want 28 %h", wlog_a[w0[7:0]], wlog_d[w0[7:0]], pk(3, 3, 3, 3)); end
        total++; if (n_both != 0) begin bad++; $display("FAIL rd_wr_overlap: got %0d want 0", n_both); end
    endtask

    initial begin
        test_reset;
        test_add;
        test_max;
        test_relu;
        test_mul_const;
        test_stall;
        test_timeout;
        test_illegal;
        test_add;
        test_reset_mid;
        test_add;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
